// File: rtl/jk_stim_driver_pkg.sv
// Shared definitions for the JK stimulus driver: FSM states and JK excitation table.
package jk_stim_driver_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Excitation codes, packed as {j, k}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // {j,k} that moves a JK flop from q to b
  function automatic logic [1:0] jk_excite(input logic q, input logic b,
                                           input logic prefer_toggle);
    logic [1:0] r;
    if (q == b)
      r = JK_HOLD;
    else if (prefer_toggle)
      r = JK_TOG;
    else if (b)
      r = JK_SET;
    else
      r = JK_RST;
    return r;
  endfunction

endpackage

// File: rtl/jk_stim_fifo.sv
// Synchronous DEPTH x 1 FIFO for target bits; extra pointer bit separates full from empty.
module jk_stim_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  // Read/write pointers, wrapping modulo DEPTH in the low bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd)
        r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/jk_stim_driver.sv
// JK excitation driver: turns queued target bits into registered j/k and checks y_fb
// two cycles after each pop against the expected bit.
module jk_stim_driver
  import jk_stim_driver_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter bit          PREFER_TOGGLE = 1'b0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             j,
  output logic             k,
  input  logic             y_fb,
  input  logic             clr_err,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_j;
  logic             r_k;
  logic             r_q;
  logic             r_exp0;
  logic             r_v0;
  logic             r_exp1;
  logic             r_v1;
  logic             r_done;
  logic             r_dcnt;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_count;

  logic       w_full;
  logic       w_empty;
  logic       w_head;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_jk_nxt;
  logic       w_q_nxt;
  logic       w_exp0_nxt;
  logic       w_v0_nxt;
  logic       w_done_nxt;
  logic       w_dcnt_nxt;
  logic       w_err;

  assign in_ready  = !w_full;
  assign w_push    = in_valid && !w_full;
  assign j         = r_j;
  assign k         = r_k;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign mismatch  = r_mismatch;
  assign err_count = r_err_count;

  jk_stim_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_din   (in_bit),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state, pop and next excitation/expectation decisions
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_jk_nxt    = JK_HOLD;
    w_q_nxt     = r_q;
    w_exp0_nxt  = r_exp0;
    w_v0_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      ST_SYNC: begin
        w_jk_nxt    = JK_RST;
        w_q_nxt     = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!w_empty)
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_jk_nxt   = jk_excite(r_q, w_head, PREFER_TOGGLE);
          w_q_nxt    = w_head;
          w_exp0_nxt = w_head;
          w_v0_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
          w_dcnt_nxt  = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (r_dcnt) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_dcnt_nxt  = 1'b0;
        end else begin
          w_dcnt_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  // State, excitation outputs, model of y and the two-stage check pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_SYNC;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_q     <= 1'b0;
      r_exp0  <= 1'b0;
      r_v0    <= 1'b0;
      r_exp1  <= 1'b0;
      r_v1    <= 1'b0;
      r_done  <= 1'b0;
      r_dcnt  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      {r_j, r_k}   <= w_jk_nxt;
      r_q          <= w_q_nxt;
      r_exp0       <= w_exp0_nxt;
      r_v0         <= w_v0_nxt;
      r_exp1       <= r_exp0;
      r_v1         <= r_v0;
      r_done       <= w_done_nxt;
      r_dcnt       <= w_dcnt_nxt;
    end
  end

  assign w_err = r_v1 && (y_fb != r_exp1);

  // Sticky mismatch and saturating error count; an error on the clear edge counts as one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mismatch  <= 1'b0;
      r_err_count <= '0;
    end else if (w_err) begin
      r_mismatch <= 1'b1;
      if (clr_err)
        r_err_count <= CNT_W'(1);
      else if (!(&r_err_count))
        r_err_count <= r_err_count + CNT_W'(1);
    end else if (clr_err) begin
      r_mismatch  <= 1'b0;
      r_err_count <= '0;
    end
  end

endmodule

// File: tb/tb_jk_stim_driver.sv
// Directed bench: two drivers (set/reset and toggle styles) each feeding a reference JK flop,
// plus a standalone FIFO instance to exercise full/ready behaviour.
module tb_jk_stim_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic clr_err = 1'b0;
  logic inv = 1'b0;

  logic in_ready0, j0, k0, busy0, done0, mismatch0;
  logic [7:0] err0;
  logic in_ready1, j1, k1, busy1, done1, mismatch1;
  logic [7:0] err1;
  logic y0, y1;

  logic f_push = 1'b0, f_din = 1'b0, f_pop = 1'b0;
  logic f_dout, f_full, f_empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jk_stim_driver #(.DEPTH(8), .PREFER_TOGGLE(1'b0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready0),
    .j(j0), .k(k0), .y_fb(y0 ^ inv), .clr_err(clr_err), .busy(busy0), .done(done0),
    .mismatch(mismatch0), .err_count(err0)
  );

  jk_stim_driver #(.DEPTH(8), .PREFER_TOGGLE(1'b1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready1),
    .j(j1), .k(k1), .y_fb(y1 ^ inv), .clr_err(clr_err), .busy(busy1), .done(done1),
    .mismatch(mismatch1), .err_count(err1)
  );

  jk_stim_fifo #(.DEPTH(8)) u_fifo (
    .clk(clk), .rst_n(rst), .i_push(f_push), .i_din(f_din), .i_pop(f_pop),
    .o_dout(f_dout), .o_full(f_full), .o_empty(f_empty)
  );

  // Reference JK flops; reset to 1 so the SYNC cycle has something to force
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y0 <= 1'b1;
      y1 <= 1'b1;
    end else begin
      case ({j0, k0})
        2'b01: y0 <= 1'b0;
        2'b10: y0 <= 1'b1;
        2'b11: y0 <= ~y0;
        default: y0 <= y0;
      endcase
      case ({j1, k1})
        2'b01: y1 <= 1'b0;
        2'b10: y1 <= 1'b1;
        2'b11: y1 <= ~y1;
        default: y1 <= y1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input int unsigned n, input logic [31:0] pat);
    int unsigned i = 0;
    int unsigned guard = 0;
    logic acc;
    while (i < n && guard < 4000) begin
      in_valid = 1'b1;
      in_bit   = pat[i % 32];
      acc      = in_ready0;
      tick();
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    chk("push_n_accepted", i, n);
  endtask

  task automatic wait_done();
    int unsigned cnt = 0;
    while (!done0 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("done_seen", done0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fb;
    fb = 10'b10_1100_1101;

    // Reset state
    tick();
    tick();
    chk("rst_jk", {j0, k0}, 2'b00);
    chk("rst_ready", in_ready0, 1'b1);
    chk("rst_busy", busy0, 1'b1);
    chk("rst_done", done0, 1'b0);
    chk("rst_mismatch", mismatch0, 1'b0);
    chk("rst_err", err0, 8'd0);
    chk("rst_fifo_empty", f_empty, 1'b1);

    // SYNC cycle then IDLE
    rst = 1'b1;
    tick();
    chk("sync_jk", {j0, k0}, 2'b01);
    chk("sync_busy", busy0, 1'b0);
    tick();
    chk("idle_jk", {j0, k0}, 2'b00);
    chk("sync_y0", y0, 1'b0);
    chk("sync_y1", y1, 1'b0);

    // Stream 1,0,0,1 into both drivers
    in_valid = 1'b1; in_bit = 1'b1;
    tick();
    in_bit = 1'b0;
    tick();
    chk("run_busy", busy0, 1'b1);
    in_bit = 1'b0;
    tick();
    chk("t1_jk0", {j0, k0}, 2'b10);
    chk("t2_jk0", {j1, k1}, 2'b11);
    in_bit = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_jk1", {j0, k0}, 2'b01);
    chk("t2_jk1", {j1, k1}, 2'b11);
    chk("t1_y0", y0, 1'b1);
    chk("t2_y0", y1, 1'b1);
    tick();
    chk("t1_jk2", {j0, k0}, 2'b00);
    chk("t2_jk2", {j1, k1}, 2'b00);
    chk("t1_y1", y0, 1'b0);
    chk("t2_y1", y1, 1'b0);
    tick();
    chk("t1_jk3", {j0, k0}, 2'b10);
    chk("t2_jk3", {j1, k1}, 2'b11);
    chk("t1_y2", y0, 1'b0);
    tick();
    chk("t1_drain_jk", {j0, k0}, 2'b00);
    chk("t1_y3", y0, 1'b1);
    chk("t2_y3", y1, 1'b1);
    tick();
    chk("t1_done_early", done0, 1'b0);
    tick();
    chk("t1_done", done0, 1'b1);
    chk("t2_done", done1, 1'b1);
    chk("t1_idle", busy0, 1'b0);
    tick();
    chk("t1_done_pulse", done0, 1'b0);
    chk("t1_mismatch", mismatch0, 1'b0);
    chk("t2_mismatch", mismatch1, 1'b0);

    // FIFO fill/full behaviour on the standalone instance
    f_pop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      f_push = 1'b1;
      f_din  = fb[i];
      chk("fifo_ready", !f_full, (i < 8));
      tick();
    end
    chk("fifo_full", f_full, 1'b1);
    f_din = fb[8]; f_pop = 1'b1;
    chk("fifo_ready_while_pop", !f_full, 1'b0);
    chk("fifo_head0", f_dout, fb[0]);
    tick();
    f_pop = 1'b0;
    chk("fifo_not_full", f_full, 1'b0);
    tick();
    chk("fifo_full_b8", f_full, 1'b1);
    f_din = fb[9]; f_pop = 1'b1;
    chk("fifo_head1", f_dout, fb[1]);
    tick();
    f_pop = 1'b0;
    tick();
    f_push = 1'b0;
    chk("fifo_full_b9", f_full, 1'b1);
    for (int i = 2; i < 10; i++) begin
      chk("fifo_order", f_dout, fb[i]);
      f_pop = 1'b1;
      tick();
    end
    f_pop = 1'b0;
    chk("fifo_empty", f_empty, 1'b1);

    // Three inverted checks
    inv = 1'b1;
    push_n(3, 32'h0000_0003);
    wait_done();
    inv = 1'b0;
    chk("err3_mismatch", mismatch0, 1'b1);
    chk("err3_count", err0, 8'd3);

    // Clear on the same edge as an error
    inv = 1'b1;
    in_valid = 1'b1; in_bit = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    inv = 1'b0;
    chk("clr_err_count", err0, 8'd1);
    chk("clr_err_mismatch", mismatch0, 1'b1);
    wait_done();

    // Clear with no error
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_count", err0, 8'd0);
    chk("clr_mismatch", mismatch0, 1'b0);

    // Saturation
    inv = 1'b1;
    push_n(254, 32'hA5C3_96E1);
    wait_done();
    chk("sat_254", err0, 8'd254);
    push_n(3, 32'h0000_0005);
    wait_done();
    inv = 1'b0;
    chk("sat_255", err0, 8'd255);
    chk("sat_mismatch", mismatch0, 1'b1);

    // Reset mid-RUN
    in_valid = 1'b1; in_bit = 1'b1;
    tick();
    in_bit = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_run_busy", busy0, 1'b1);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_jk", {j0, k0}, 2'b00);
    chk("mid_rst_ready", in_ready0, 1'b1);
    chk("mid_rst_err", err0, 8'd0);
    chk("mid_rst_mismatch", mismatch0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("resync_jk", {j0, k0}, 2'b01);
    chk("resync_busy", busy0, 1'b0);
    tick();
    chk("resync_idle_jk", {j0, k0}, 2'b00);
    tick();
    tick();
    chk("discarded_busy", busy0, 1'b0);
    chk("discarded_jk", {j0, k0}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
